// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, FSM state
// codes, ALU control codes, ALU operation classes and datapath mux selects.
package riscv_pkg;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Controller state encoding
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ImmSrc selects
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; R-type and unknown ops use I
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

    // True for the opcodes this controller can sequence
    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL: op_supported = 1'b1;
            default:                                         op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus instruction fields
// onto the ALUControl code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    // Fixed add/sub for address and branch work, funct3-driven for execute
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type (sub possible) from I-ALU (addi only)
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: Moore FSM sequencing lw, sw, R-type,
// I-ALU, beq and jal, plus opcode-driven ImmSrc and an Illegal pulse.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;

    // State register; reset drops straight back to FETCH at any point
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // Next-state selection by current state and opcode
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_IALU:      w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; anything not named in a state stays 0
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_WDATA;
        w_alu_op    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcA     = SRCA_PC;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                ResultSrc   = RES_ALUOUT;
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_REG;
                ALUSrcB  = SRCB_WDATA;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_REG;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_WDATA;
                w_alu_op  = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                w_branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALUOUT;
                w_pc_update = 1'b1;
            end
            default: begin
                w_pc_update = 1'b0;
            end
        endcase
    end

    assign w_illegal = (r_state == S_DECODE) && !op_supported(op);
    assign ImmSrc    = imm_src(op);

    // FETCH is the reset state yet drives write enables, so all enables are
    // qualified by reset to keep them quiet while reset is held low.
    assign PCWrite  = reset & (w_pc_update | (w_branch & Zero));
    assign MemWrite = reset & w_mem_write;
    assign IRWrite  = reset & w_ir_write;
    assign RegWrite = reset & w_reg_write;
    assign Illegal  = reset & w_illegal;

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction
// sequences followed by random instructions, compared cycle by cycle against
// an instruction-level timeline model.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] rsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic       regw;
        logic       ill;
    } ctl_t;

    ctl_t obs;
    ctl_t exp_q[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, RegWrite, Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t mk(input logic pcw, input logic adr, input logic memw,
                                input logic irw, input logic [1:0] rsrc,
                                input logic [1:0] srca, input logic [1:0] srcb,
                                input logic [2:0] aluc, input logic regw,
                                input logic ill);
        mk = {pcw, adr, memw, irw, rsrc, srca, srcb, aluc, regw, ill};
    endfunction

    // ALU operation an R/I arithmetic instruction asks for
    function automatic logic [2:0] alu_expect(input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7);
        case (f3)
            3'b000:  alu_expect = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  alu_expect = 3'b101;
            3'b110:  alu_expect = 3'b011;
            3'b111:  alu_expect = 3'b010;
            default: alu_expect = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_expect(input logic [6:0] o);
        case (o)
            7'b0100011: imm_expect = 2'b01;
            7'b1100011: imm_expect = 2'b10;
            7'b1101111: imm_expect = 2'b11;
            default:    imm_expect = 2'b00;
        endcase
    endfunction

    // Control bundle seen while reset is held: FETCH selects, no enables
    function automatic ctl_t reset_bundle();
        reset_bundle = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    endfunction

    // Builds the per-cycle control timeline of one whole instruction
    task automatic plan(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z);
        ctl_t fetch, decode, addr, aluwb;
        fetch  = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
        decode = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
        addr   = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
        aluwb  = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        exp_q.delete();
        exp_q.push_back(fetch);
        case (o)
            7'b0000011: begin
                exp_q.push_back(decode);
                exp_q.push_back(addr);
                exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
            end
            7'b0100011: begin
                exp_q.push_back(decode);
                exp_q.push_back(addr);
                exp_q.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            end
            7'b0110011: begin
                exp_q.push_back(decode);
                exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_expect(o, f3, f7), 0, 0));
                exp_q.push_back(aluwb);
            end
            7'b0010011: begin
                exp_q.push_back(decode);
                exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_expect(o, f3, f7), 0, 0));
                exp_q.push_back(aluwb);
            end
            7'b1100011: begin
                exp_q.push_back(decode);
                exp_q.push_back(mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0));
            end
            7'b1101111: begin
                exp_q.push_back(decode);
                exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
                exp_q.push_back(aluwb);
            end
            default: begin
                exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 1));
            end
        endcase
    endtask

    task automatic check_ctl(input string tag, input ctl_t o_v, input ctl_t e_v);
        checks++;
        assert (o_v === e_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o_v, e_v);
        end
    endtask

    task automatic check_imm(input string tag, input logic [1:0] o_v, input logic [1:0] e_v);
        checks++;
        assert (o_v === e_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o_v, e_v);
        end
    endtask

    // Starts at a falling edge in FETCH; steps through the instruction and
    // returns on the falling edge of the following FETCH cycle.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        plan(o, f3, f7, z);
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            check_ctl($sformatf("%s_c%0d", name, k + 1), obs, exp_q[k]);
            check_imm($sformatf("%s_imm_c%0d", name, k + 1), ImmSrc, imm_expect(o));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] r_op;
        ctl_t mr;
        reset    = 1'b0;
        op       = 7'b0000011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_ctl("reset_hold", obs, reset_bundle());
        check_imm("reset_imm", ImmSrc, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr("i_add", 7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
        run_instr("r_slt", 7'b0110011, 3'b010, 1'b0, 1'b0);
        run_instr("r_or", 7'b0110011, 3'b110, 1'b0, 1'b0);
        run_instr("i_and", 7'b0010011, 3'b111, 1'b0, 1'b0);
        run_instr("r_xor", 7'b0110011, 3'b100, 1'b1, 1'b0);
        run_instr("after_illegal", 7'b0000011, 3'b010, 1'b0, 1'b0);

        // lw interrupted by reset part-way through its MEMREAD cycle
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        plan(op, funct3, funct7b5, Zero);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_ctl($sformatf("mr_c%0d", k + 1), obs, exp_q[k]);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        mr = exp_q[3];
        check_ctl("mr_memread", obs, mr);
        #1 reset = 1'b0;
        #1;
        check_ctl("mr_async_reset", obs, reset_bundle());
        @(posedge clk);
        @(negedge clk);
        #1;
        check_ctl("mr_reset_held", obs, reset_bundle());
        @(negedge clk);
        reset = 1'b1;
        run_instr("mr_restart", 7'b0100011, 3'b010, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: r_op = 7'b0000011;
                1: r_op = 7'b0100011;
                2: r_op = 7'b0110011;
                3: r_op = 7'b0010011;
                4: r_op = 7'b1100011;
                5: r_op = 7'b1101111;
                default: r_op = 7'($urandom);
            endcase
            run_instr($sformatf("rnd%0d_op%b", n, r_op), r_op, 3'($urandom),
                      1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
